// File: rtl/ram_burst_decoder.sv
// ram_burst_decoder
// Rebuilds synchronous-burst RAM transactions from the per-edge sampled bus
// (one filter_strobe per RAM clock edge) and queues one event per enabled
// data beat into a show-ahead FIFO with a valid/ready consumer interface.
// Events that arrive while the FIFO is full and not being popped are dropped
// and counted.

module ram_burst_decoder #(
  parameter int WAIT_CYCLES = 3,
  parameter int FIFO_LOG2   = 4
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [22:0] filter_a,
  input  logic [15:0] filter_d,
  input  logic [1:0]  filter_ublb,
  input  logic        filter_read,
  input  logic        filter_write,
  input  logic        filter_addr_latch,
  input  logic        filter_strobe,
  input  logic        clear_overflow,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic        ev_write,
  output logic [1:0]  ev_ublb,
  output logic [22:0] ev_addr,
  output logic [15:0] ev_data,
  output logic        overflow,
  output logic [15:0] drop_count
);

  // ---------------------------------------------------------------------------
  // Constants and types
  // ---------------------------------------------------------------------------
  localparam int          DEPTH     = 1 << FIFO_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam int          EV_W      = 1 + 2 + 23 + 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  ublb;
    logic [22:0] addr;
    logic [15:0] data;
  } event_t;

  // ---------------------------------------------------------------------------
  // Burst tracker state
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [22:0] base_q,  base_d;
  logic [22:0] beat_q,  beat_d;
  logic [3:0]  wcnt_q,  wcnt_d;

  // Event produced by the tracker in the current cycle (pushed at this edge)
  logic        emit;
  event_t      emit_ev;

  // Next-state logic: only a strobe cycle moves the burst tracker.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    wcnt_d  = wcnt_q;
    emit    = 1'b0;
    emit_ev = '0;

    if (filter_strobe) begin
      if (filter_addr_latch) begin
        // A latch restarts the burst from any state, even mid-burst.
        base_d  = filter_a;
        beat_d  = '0;
        wcnt_d  = WAIT_INIT;
        state_d = (WAIT_CYCLES == 0) ? ST_DATA : ST_WAIT;
      end else if (!filter_read && !filter_write) begin
        // Bus released: the burst is over until the next latch.
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_d = ST_IDLE;
          end
          ST_WAIT: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q <= 4'd1) begin
              state_d = ST_DATA;
            end
          end
          ST_DATA: begin
            beat_d = beat_q + 23'd1;
            // A beat with no byte lanes enabled still advances the address.
            if (filter_ublb != 2'b00) begin
              emit          = 1'b1;
              // Read and write both asserted is treated as a read.
              emit_ev.write = filter_write & ~filter_read;
              emit_ev.ublb  = filter_ublb;
              emit_ev.addr  = base_q + beat_q;
              emit_ev.data  = filter_d;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  // Burst tracker registers.
  always_ff @(posedge mclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      beat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO (show-ahead, pointers carry one extra wrap bit)
  // ---------------------------------------------------------------------------
  logic [FIFO_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [EV_W-1:0]      mem_q [DEPTH];

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  event_t               head_ev;

  // FIFO status and the push/pop/drop decisions for this cycle.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[FIFO_LOG2] != rd_ptr_q[FIFO_LOG2]) &&
                 (wr_ptr_q[FIFO_LOG2-1:0] == rd_ptr_q[FIFO_LOG2-1:0]);
    pop        = ~fifo_empty & ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = emit & (~fifo_full | pop);
    drop       = emit & fifo_full & ~pop;
    wr_ptr_d   = push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
  end

  // FIFO pointers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge mclk) begin
    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers alone, and stale entries are never presented while invalid.
    if (push && !reset) begin
      mem_q[wr_ptr_q[FIFO_LOG2-1:0]] <= emit_ev;
    end
  end

  // Head presentation: fields read as zero whenever nothing is queued.
  always_comb begin
    head_ev  = fifo_empty ? '0 : event_t'(mem_q[rd_ptr_q[FIFO_LOG2-1:0]]);
    ev_valid = ~fifo_empty;
    ev_write = head_ev.write;
    ev_ublb  = head_ev.ublb;
    ev_addr  = head_ev.addr;
    ev_data  = head_ev.data;
  end

  // ---------------------------------------------------------------------------
  // Overflow flag and saturating drop counter
  // ---------------------------------------------------------------------------
  logic        overflow_q,   overflow_d;
  logic [15:0] drop_count_q, drop_count_d;

  // A drop wins over a simultaneous clear and becomes the first counted drop.
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clear_overflow) begin
        drop_count_d = 16'd1;
      end else if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end else if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  // Overflow registers.
  always_ff @(posedge mclk) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ram_burst_decoder.sv
// Testbench for ram_burst_decoder: a transaction-level model (burst walker
// plus event queue) checked against the DUT every cycle, and directed
// scenarios with literal expectations.

module tb_ram_burst_decoder;

  localparam int WAIT = 3;
  localparam int QMAX = 16;

  logic        mclk = 1'b0;
  logic        reset;
  logic [22:0] filter_a;
  logic [15:0] filter_d;
  logic [1:0]  filter_ublb;
  logic        filter_read;
  logic        filter_write;
  logic        filter_addr_latch;
  logic        filter_strobe;
  logic        clear_overflow;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_write;
  logic [1:0]  ev_ublb;
  logic [22:0] ev_addr;
  logic [15:0] ev_data;
  logic        overflow;
  logic [15:0] drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  ram_burst_decoder #(.WAIT_CYCLES(WAIT), .FIFO_LOG2(4)) dut (
    .mclk              (mclk),
    .reset             (reset),
    .filter_a          (filter_a),
    .filter_d          (filter_d),
    .filter_ublb       (filter_ublb),
    .filter_read       (filter_read),
    .filter_write      (filter_write),
    .filter_addr_latch (filter_addr_latch),
    .filter_strobe     (filter_strobe),
    .clear_overflow    (clear_overflow),
    .ev_valid          (ev_valid),
    .ev_ready          (ev_ready),
    .ev_write          (ev_write),
    .ev_ublb           (ev_ublb),
    .ev_addr           (ev_addr),
    .ev_data           (ev_data),
    .overflow          (overflow),
    .drop_count        (drop_count)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a burst walker that tracks "waits still to skip" and "next address",
  // feeding a queue of expected events with a 16-entry limit.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [1:0]  ublb;
    logic [22:0] addr;
    logic [15:0] data;
  } ev_t;

  ev_t q[$];
  bit  m_active    = 0;
  int  m_wait_left = 0;
  int  m_next_addr = 0;
  bit  m_ovf       = 0;
  int  m_drops     = 0;

  always @(posedge mclk) begin
    bit  have_ev;
    ev_t e;
    have_ev = 0;
    e = '{wr: 1'b0, ublb: 2'b00, addr: 23'h0, data: 16'h0};
    if (reset) begin
      q.delete();
      m_active = 0; m_wait_left = 0; m_next_addr = 0;
      m_ovf = 0; m_drops = 0;
    end else begin
      if (filter_strobe) begin
        if (filter_addr_latch) begin
          m_active = 1; m_wait_left = WAIT; m_next_addr = int'(filter_a);
        end else if (!filter_read && !filter_write) begin
          m_active = 0;
        end else if (m_active) begin
          if (m_wait_left > 0) begin
            m_wait_left--;
          end else begin
            if (filter_ublb != 2'b00) begin
              have_ev = 1;
              e.wr = filter_write && !filter_read;
              e.ublb = filter_ublb;
              e.addr = 23'(m_next_addr);
              e.data = filter_d;
            end
            m_next_addr = (m_next_addr + 1) % (1 << 23);
          end
        end
      end
      if (q.size() > 0 && ev_ready) void'(q.pop_front());
      if (have_ev) begin
        if (q.size() < QMAX) begin
          q.push_back(e);
        end else begin
          m_ovf = 1;
          m_drops = clear_overflow ? 1 : ((m_drops < 65535) ? m_drops + 1 : 65535);
        end
      end else if (clear_overflow) begin
        m_ovf = 0; m_drops = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge mclk) begin
    if (!reset) begin
      check("valid", {31'd0, ev_valid}, {31'd0, q.size() != 0});
      check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("drop_count", {16'd0, drop_count}, 32'(m_drops));
      if (q.size() != 0) begin
        check("head_write", {31'd0, ev_write}, {31'd0, q[0].wr});
        check("head_ublb", {30'd0, ev_ublb}, {30'd0, q[0].ublb});
        check("head_addr", {9'd0, ev_addr}, {9'd0, q[0].addr});
        check("head_data", {16'd0, ev_data}, {16'd0, q[0].data});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic al, input logic rd, input logic wr,
                       input logic [22:0] a, input logic [15:0] d, input logic [1:0] ub);
    filter_addr_latch = al; filter_read = rd; filter_write = wr;
    filter_a = a; filter_d = d; filter_ublb = ub; filter_strobe = 1'b1;
    @(negedge mclk);
    filter_strobe = 1'b0; filter_addr_latch = 1'b0;
    filter_read = 1'b0; filter_write = 1'b0; filter_ublb = 2'b00;
  endtask

  task automatic gap();
    @(negedge mclk);
  endtask

  task automatic send(input logic al, input logic rd, input logic wr,
                      input logic [22:0] a, input logic [15:0] d, input logic [1:0] ub);
    drive(al, rd, wr, a, d, ub);
    gap();
  endtask

  task automatic latch_and_wait(input logic [22:0] a);
    send(1'b1, 1'b0, 1'b0, a, 16'h0, 2'b00);
    for (int i = 0; i < WAIT; i++) send(1'b0, 1'b1, 1'b0, 23'h0, 16'h0, 2'b11);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(negedge mclk);
    ev_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [1:0]  ub_seq [4];
    logic [22:0] wrap_addr [4];
    ub_seq    = '{2'd3, 2'd0, 2'd1, 2'd2};
    wrap_addr = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};

    reset = 1'b1; ev_ready = 1'b0; clear_overflow = 1'b0;
    filter_a = '0; filter_d = '0; filter_ublb = '0; filter_read = 1'b0;
    filter_write = 1'b0; filter_addr_latch = 1'b0; filter_strobe = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst_valid", {31'd0, ev_valid}, 32'd0);
    check("rst_addr", {9'd0, ev_addr}, 32'd0);
    check("rst_data", {16'd0, ev_data}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_drops", {16'd0, drop_count}, 32'd0);
    reset = 1'b0;
    gap();

    // 1) Read burst at 0x001000, valid rises one cycle after the first beat
    latch_and_wait(23'h001000);
    check("s1_pre_valid", {31'd0, ev_valid}, 32'd0);
    drive(1'b0, 1'b1, 1'b0, 23'h0, 16'h00A0, 2'b11);
    check("s1_valid_rise", {31'd0, ev_valid}, 32'd1);
    check("s1_first_addr", {9'd0, ev_addr}, 32'h001000);
    gap();
    for (int i = 1; i < 4; i++) send(1'b0, 1'b1, 1'b0, 23'h0, 16'(16'h00A0 + i), 2'b11);
    check("s1_model_n", 32'(q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("s1_addr", {9'd0, ev_addr}, 32'h001000 + 32'(i));
      check("s1_data", {16'd0, ev_data}, 32'h00A0 + 32'(i));
      check("s1_dir", {31'd0, ev_write}, 32'd0);
      pop_one();
    end
    check("s1_drained", {31'd0, ev_valid}, 32'd0);

    // 2) Write burst with lanes 3,0,1,2: beat 1 skipped
    latch_and_wait(23'h002000);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 1'b1, 23'h0, 16'(16'h00B0 + i), ub_seq[i]);
    check("s2_model_n", 32'(q.size()), 32'd3);
    check("s2_addr0", {9'd0, ev_addr}, 32'h002000);
    check("s2_ublb0", {30'd0, ev_ublb}, 32'd3);
    check("s2_dir0", {31'd0, ev_write}, 32'd1);
    pop_one();
    check("s2_addr1", {9'd0, ev_addr}, 32'h002002);
    check("s2_ublb1", {30'd0, ev_ublb}, 32'd1);
    pop_one();
    check("s2_addr2", {9'd0, ev_addr}, 32'h002003);
    check("s2_ublb2", {30'd0, ev_ublb}, 32'd2);
    check("s2_data2", {16'd0, ev_data}, 32'h00B3);
    pop_one();

    // 3) Address wrap at the top of the 23-bit space; rd+wr counts as read
    latch_and_wait(23'h7FFFFE);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1, (i == 2), 23'h0, 16'(i), 2'b11);
    for (int i = 0; i < 4; i++) begin
      check("s3_wrap_addr", {9'd0, ev_addr}, {9'd0, wrap_addr[i]});
      check("s3_dir", {31'd0, ev_write}, 32'd0);
      pop_one();
    end

    // 4) Bus release ends the burst; a latch mid-burst restarts with full wait
    latch_and_wait(23'h003000);
    send(1'b0, 1'b1, 1'b0, 23'h0, 16'h00C0, 2'b11);
    send(1'b0, 1'b1, 1'b0, 23'h0, 16'h00C1, 2'b11);
    send(1'b0, 1'b0, 1'b0, 23'h0, 16'h0, 2'b11);
    send(1'b0, 1'b1, 1'b0, 23'h0, 16'h00C2, 2'b11);
    send(1'b0, 1'b1, 1'b0, 23'h0, 16'h00C3, 2'b11);
    check("s4_idle_n", 32'(q.size()), 32'd2);
    latch_and_wait(23'h004000);
    send(1'b0, 1'b1, 1'b0, 23'h0, 16'h00D0, 2'b11);
    send(1'b1, 1'b0, 1'b0, 23'h005000, 16'h0, 2'b00);
    for (int i = 0; i < WAIT; i++) send(1'b0, 1'b1, 1'b0, 23'h0, 16'h00EE, 2'b11);
    check("s4_wait_n", 32'(q.size()), 32'd3);
    send(1'b0, 1'b1, 1'b0, 23'h0, 16'h00E0, 2'b11);
    check("s4_final_n", 32'(q.size()), 32'd4);
    check("s4_h0", {9'd0, ev_addr}, 32'h003000); pop_one();
    check("s4_h1", {9'd0, ev_addr}, 32'h003001); pop_one();
    check("s4_h2", {9'd0, ev_addr}, 32'h004000); pop_one();
    check("s4_h3", {9'd0, ev_addr}, 32'h005000);
    check("s4_h3d", {16'd0, ev_data}, 32'h00E0); pop_one();

    // 5) 20 beats into a stalled FIFO: 16 kept, 4 dropped
    latch_and_wait(23'h000100);
    for (int i = 0; i < 20; i++) send(1'b0, 1'b1, 1'b0, 23'h0, 16'(i), 2'b11);
    check("s5_model_n", 32'(q.size()), 32'd16);
    check("s5_ovf", {31'd0, overflow}, 32'd1);
    check("s5_drops", {16'd0, drop_count}, 32'd4);
    for (int i = 0; i < 16; i++) begin
      check("s5_addr", {9'd0, ev_addr}, 32'h000100 + 32'(i));
      check("s5_data", {16'd0, ev_data}, 32'(i));
      pop_one();
    end
    check("s5_empty", {31'd0, ev_valid}, 32'd0);
    clear_overflow = 1'b1; @(negedge mclk); clear_overflow = 1'b0;
    check("s5_clr_ovf", {31'd0, overflow}, 32'd0);
    check("s5_clr_drops", {16'd0, drop_count}, 32'd0);

    // 6) Full FIFO with simultaneous pop, drop vs clear, then reset mid-burst
    latch_and_wait(23'h000200);
    for (int i = 0; i < 16; i++) send(1'b0, 1'b1, 1'b0, 23'h0, 16'(i), 2'b11);
    check("s6_full_n", 32'(q.size()), 32'd16);
    ev_ready = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 23'h0, 16'h0010, 2'b11);
    ev_ready = 1'b0;
    check("s6_pp_ovf", {31'd0, overflow}, 32'd0);
    check("s6_pp_n", 32'(q.size()), 32'd16);
    check("s6_pp_head", {9'd0, ev_addr}, 32'h000201);
    gap();
    send(1'b0, 1'b1, 1'b0, 23'h0, 16'h0011, 2'b11);
    check("s6_drop_ovf", {31'd0, overflow}, 32'd1);
    check("s6_drop_cnt", {16'd0, drop_count}, 32'd1);
    clear_overflow = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 23'h0, 16'h0012, 2'b11);
    clear_overflow = 1'b0;
    check("s6_clr_drop_ovf", {31'd0, overflow}, 32'd1);
    check("s6_clr_drop_cnt", {16'd0, drop_count}, 32'd1);
    gap();
    reset = 1'b1; @(negedge mclk); reset = 1'b0;
    check("s6_rst_valid", {31'd0, ev_valid}, 32'd0);
    check("s6_rst_ovf", {31'd0, overflow}, 32'd0);
    check("s6_rst_drops", {16'd0, drop_count}, 32'd0);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, 1'b0, 23'h0, 16'h0F00, 2'b11);
    check("s6_post_rst_valid", {31'd0, ev_valid}, 32'd0);
    latch_and_wait(23'h000600);
    send(1'b0, 1'b1, 1'b0, 23'h0, 16'h0600, 2'b11);
    check("s6_relatch_valid", {31'd0, ev_valid}, 32'd1);
    check("s6_relatch_addr", {9'd0, ev_addr}, 32'h000600);
    pop_one();
    gap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
